// File: rtl/arb_pkg.sv
// Shared definitions for the four-way round-robin arbiter.
// Holds the state encoding and the rotating priority search.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // First set bit of req searching ptr, ptr+1, ... with wrap; one-hot result.
    function automatic logic [N_REQ-1:0] rotating_first(
        input logic [N_REQ-1:0] req,
        input logic [ID_W-1:0]  ptr
    );
        logic [N_REQ-1:0] res;
        logic             found;
        logic [ID_W-1:0]  idx;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = ptr + ID_W'(i);
            if (req[idx] && !found) begin
                res[idx] = 1'b1;
                found    = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [ID_W-1:0] onehot_index(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/onehot_to_bin4.sv
// Combinational 4-bit one-hot to 2-bit binary encoder with a separate valid flag.
// An all-zero input encodes to 0 with valid low.
module onehot_to_bin4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] onehot,
    output logic [ID_W-1:0]  bin,
    output logic             valid
);

    assign bin   = {onehot[3] | onehot[2], onehot[3] | onehot[1]};
    assign valid = |onehot;

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot grant, binary index
// and an optional hold-time limit that revokes a grant and forces rotation.
module rr_arbiter_4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             timeout
);

    // Keep the counter at least one bit wide so MAX_HOLD=0 still elaborates.
    localparam int               CNT_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_reg,   state_next;
    logic [N_REQ-1:0] gnt_reg,     gnt_next;
    logic [ID_W-1:0]  ptr_reg,     ptr_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic             timeout_reg, timeout_next;

    logic             owner_req;
    logic             limit_hit;
    logic             do_arb;
    logic [N_REQ-1:0] cand;
    logic [N_REQ-1:0] pick;

    assign owner_req = |(req & gnt_reg);
    assign limit_hit = (MAX_HOLD != 0) && (cnt_reg == CNT_MAX);

    always_comb begin
        state_next   = state_reg;
        gnt_next     = gnt_reg;
        ptr_next     = ptr_reg;
        cnt_next     = cnt_reg;
        timeout_next = 1'b0;
        do_arb       = 1'b0;
        cand         = req;
        pick         = '0;

        case (state_reg)
            IDLE: begin
                do_arb = 1'b1;
            end
            BUSY: begin
                if (!owner_req) begin
                    // Release takes precedence over revocation on the same edge.
                    do_arb = 1'b1;
                end else if (limit_hit) begin
                    timeout_next = 1'b1;
                    do_arb       = 1'b1;
                    cand         = req & ~gnt_reg;
                end else if (MAX_HOLD != 0) begin
                    cnt_next = cnt_reg + CNT_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (do_arb) begin
            pick = rotating_first(cand, ptr_reg);
            if (|pick) begin
                state_next = BUSY;
                gnt_next   = pick;
                ptr_next   = onehot_index(pick) + ID_W'(1);
                cnt_next   = CNT_ONE;
            end else begin
                state_next = IDLE;
                gnt_next   = '0;
                cnt_next   = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            gnt_reg     <= '0;
            ptr_reg     <= '0;
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            gnt_reg     <= gnt_next;
            ptr_reg     <= ptr_next;
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
        end
    end

    assign gnt     = gnt_reg;
    assign timeout = timeout_reg;

    onehot_to_bin4 u_enc (
        .onehot (gnt_reg),
        .bin    (gnt_id),
        .valid  (gnt_valid)
    );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Scoreboard bench for rr_arbiter_4 with MAX_HOLD=4: directed req vectors push
// hand-computed expected outputs tagged with the cycle they must appear in.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  g;
        logic [1:0]  id;
        logic        to;
        string       name;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc    = 0;
    int          checks = 0;
    int          errors = 0;

    rr_arbiter_4 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input exp_t e);
        logic ev;
        ev = (e.g != 4'b0000);
        checks++;
        if (gnt !== e.g || gnt_id !== e.id || gnt_valid !== ev || timeout !== e.to) begin
            errors++;
            $display("FAIL %s: got gnt=%b id=%0d valid=%b timeout=%b, expected gnt=%b id=%0d valid=%b timeout=%b",
                     e.name, gnt, gnt_id, gnt_valid, timeout, e.g, e.id, ev, e.to);
        end else begin
            $display("ok   %s: gnt=%b id=%0d valid=%b timeout=%b", e.name, gnt, gnt_id, gnt_valid, timeout);
        end
    endtask

    task automatic expect_at(input string nm, input int unsigned c, input logic [3:0] g,
                             input logic [1:0] id, input logic to);
        exp_t e;
        e.cyc  = c;
        e.g    = g;
        e.id   = id;
        e.to   = to;
        e.name = nm;
        q.push_back(e);
    endtask

    // Drive req just after an edge; the response is due after the following edge.
    task automatic step(input string nm, input logic [3:0] r, input logic [3:0] g,
                        input logic [1:0] id, input logic to);
        @(posedge clk);
        #1;
        req = r;
        expect_at(nm, cyc + 1, g, id, to);
    endtask

    // Monitor: compare every scoreboard entry whose cycle has arrived.
    initial begin
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                check(q.pop_front());
            end
        end
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        expect_at("reset_state", cyc, 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 5; i++) begin
            step("idle", 4'b0000, 4'b0000, 2'd0, 1'b0);
        end

        // Rotation with every requester active, each owner dropping for one cycle.
        step("rot_g0",      4'b1111, 4'b0001, 2'd0, 1'b0);
        step("rot_g0_hold", 4'b1111, 4'b0001, 2'd0, 1'b0);
        step("rot_g1",      4'b1110, 4'b0010, 2'd1, 1'b0);
        step("rot_g1_hold", 4'b1111, 4'b0010, 2'd1, 1'b0);
        step("rot_g2",      4'b1101, 4'b0100, 2'd2, 1'b0);
        step("rot_g2_hold", 4'b1111, 4'b0100, 2'd2, 1'b0);
        step("rot_g3",      4'b1011, 4'b1000, 2'd3, 1'b0);
        step("rot_g3_hold", 4'b1111, 4'b1000, 2'd3, 1'b0);
        step("rot_wrap_g0", 4'b0111, 4'b0001, 2'd0, 1'b0);
        step("rot_idle",    4'b0000, 4'b0000, 2'd0, 1'b0);

        // Pointer after granting 2 favours requester 3 over 0.
        step("g2",          4'b0100, 4'b0100, 2'd2, 1'b0);
        step("g2_release",  4'b0000, 4'b0000, 2'd0, 1'b0);
        step("ptr3_wins",   4'b1001, 4'b1000, 2'd3, 1'b0);
        step("idle_b",      4'b0000, 4'b0000, 2'd0, 1'b0);

        // Hold limit with another requester waiting.
        step("lim_g0_c1",   4'b0011, 4'b0001, 2'd0, 1'b0);
        step("lim_g0_c2",   4'b0011, 4'b0001, 2'd0, 1'b0);
        step("lim_g0_c3",   4'b0011, 4'b0001, 2'd0, 1'b0);
        step("lim_g0_c4",   4'b0011, 4'b0001, 2'd0, 1'b0);
        step("revoke_g1",   4'b0011, 4'b0010, 2'd1, 1'b1);
        step("to_clears",   4'b0010, 4'b0010, 2'd1, 1'b0);
        step("idle_c",      4'b0000, 4'b0000, 2'd0, 1'b0);

        // Hold limit with nobody else waiting: one idle cycle, then re-grant.
        step("solo_c1",     4'b0001, 4'b0001, 2'd0, 1'b0);
        step("solo_c2",     4'b0001, 4'b0001, 2'd0, 1'b0);
        step("solo_c3",     4'b0001, 4'b0001, 2'd0, 1'b0);
        step("solo_c4",     4'b0001, 4'b0001, 2'd0, 1'b0);
        step("solo_revoke", 4'b0001, 4'b0000, 2'd0, 1'b1);
        step("solo_regrant",4'b0001, 4'b0001, 2'd0, 1'b0);
        step("idle_d",      4'b0000, 4'b0000, 2'd0, 1'b0);

        // Release on the edge the counter reaches the limit: plain handoff.
        step("rel_g1_c1",   4'b0110, 4'b0010, 2'd1, 1'b0);
        step("rel_g1_c2",   4'b0110, 4'b0010, 2'd1, 1'b0);
        step("rel_g1_c3",   4'b0110, 4'b0010, 2'd1, 1'b0);
        step("rel_g1_c4",   4'b0110, 4'b0010, 2'd1, 1'b0);
        step("rel_wins",    4'b0100, 4'b0100, 2'd2, 1'b0);
        step("g2_hold",     4'b0100, 4'b0100, 2'd2, 1'b0);

        // Asynchronous reset in the middle of a grant.
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        e.cyc  = cyc;
        e.g    = 4'b0000;
        e.id   = 2'd0;
        e.to   = 1'b0;
        e.name = "async_rst";
        check(e);
        req = 4'b1111;
        expect_at("rst_held", cyc + 1, 4'b0000, 2'd0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_at("post_rst_g0", cyc + 1, 4'b0001, 2'd0, 1'b0);
        step("post_rst_g1", 4'b1110, 4'b0010, 2'd1, 1'b0);
        step("final_idle",  4'b0000, 4'b0000, 2'd0, 1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
